seven_segment_scan_reader: RTL and testbench

SEVEN_SEGMENT_SCAN_READER -- requirements
Module: seven_segment_scan_reader

---
 rtl/seven_seg_pkg.sv | 46 ++++
 rtl/seven_segment_pattern_decoder.sv | 42 ++++
 rtl/seven_segment_scan_reader.sv | 169 ++++++++++++++++
 tb/tb_seven_segment_scan_reader.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
//   Shared constants and helpers for the seven-segment scan reader.
//   Segment patterns are ordered {a,b,c,d,e,f,g}, bit6 = a ... bit0 = g,
//   active-high.
// -----------------------------------------------------------------------------
package seven_seg_pkg;

    localparam int SEG_W = 7;
    localparam int NIB_W = 4;
    localparam int NUM_DIGITS = 4;

    // Recognised digit patterns
    localparam logic [SEG_W-1:0] SEG_0 = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b1111011;

    // A dark digit is legal and reported as a blank nibble
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    localparam logic [NIB_W-1:0] NIB_BLANK = 4'hF;
    localparam logic [NIB_W-1:0] NIB_ERR   = 4'hE;

    // True when exactly one digit enable is asserted
    function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] en);
        return (en != '0) && ((en & (en - 1'b1)) == '0);
    endfunction

    // Index of the asserted enable; only meaningful when is_onehot(en)
    function automatic logic [1:0] onehot_to_index(input logic [NUM_DIGITS-1:0] en);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (en[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage : seven_seg_pkg

// File: rtl/seven_segment_pattern_decoder.sv
// -----------------------------------------------------------------------------
// seven_segment_pattern_decoder
//   Purely combinational map from a 7-bit segment pattern to a hex nibble.
//   Exact matches only: digits 0..9 decode to their value, an all-dark
//   pattern decodes to NIB_BLANK, anything else decodes to NIB_ERR with
//   error asserted.
//
// Ports
//   seg_in  in   7  segment lines, bit6 = a ... bit0 = g
//   nibble  out  4  decoded value
//   error   out  1  pattern was not recognised
// -----------------------------------------------------------------------------
module seven_segment_pattern_decoder
    import seven_seg_pkg::*;
(
    input  logic [SEG_W-1:0] seg_in,
    output logic [NIB_W-1:0] nibble,
    output logic             error
);

    // NOTE: every output gets a default before the case so no path can leave
    // it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        nibble = NIB_ERR;
        error  = 1'b1;
        case (seg_in)
            SEG_0:     begin nibble = 4'h0;      error = 1'b0; end
            SEG_1:     begin nibble = 4'h1;      error = 1'b0; end
            SEG_2:     begin nibble = 4'h2;      error = 1'b0; end
            SEG_3:     begin nibble = 4'h3;      error = 1'b0; end
            SEG_4:     begin nibble = 4'h4;      error = 1'b0; end
            SEG_5:     begin nibble = 4'h5;      error = 1'b0; end
            SEG_6:     begin nibble = 4'h6;      error = 1'b0; end
            SEG_7:     begin nibble = 4'h7;      error = 1'b0; end
            SEG_8:     begin nibble = 4'h8;      error = 1'b0; end
            SEG_9:     begin nibble = 4'h9;      error = 1'b0; end
            SEG_BLANK: begin nibble = NIB_BLANK; error = 1'b0; end
            default:   begin nibble = NIB_ERR;   error = 1'b1; end
        endcase
    end

endmodule : seven_segment_pattern_decoder

// File: rtl/seven_segment_scan_reader.sv
// -----------------------------------------------------------------------------
// seven_segment_scan_reader
//   Reads back a multiplexed 4-digit seven-segment display. Each clock the
//   {dig_en, seg_in} pair is sampled; once the same sample has been seen
//   STABLE_CYCLES times in a row with a single digit enabled, that digit is
//   decoded into a shadow frame. When all four digits have been captured
//   the shadow frame is published on digits/err with a one-cycle valid.
//   stale flags that no digit has been accepted for TIMEOUT_CYCLES cycles.
//
// Parameters
//   STABLE_CYCLES   2..255        identical samples needed to accept a digit
//   TIMEOUT_CYCLES  1..2^24-1     idle cycles before stale asserts
//
// Ports
//   clk     in   1   rising-edge clock
//   rst_n   in   1   asynchronous active-low reset
//   seg_in  in   7   segment lines a..g (bit6 = a), active-high
//   dig_en  in   4   digit enables, one-hot while a digit is driven
//   digits  out  16  last complete frame, digit i at [4i+3:4i]
//   valid   out  1   one-cycle pulse when digits/err update
//   err     out  4   per-digit unrecognised-pattern flags of last frame
//   stale   out  1   no digit accepted for TIMEOUT_CYCLES cycles
// -----------------------------------------------------------------------------
module seven_segment_scan_reader
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [SEG_W-1:0]            seg_in,
    input  logic [NUM_DIGITS-1:0]       dig_en,
    output logic [NUM_DIGITS*NIB_W-1:0] digits,
    output logic                        valid,
    output logic [NUM_DIGITS-1:0]       err,
    output logic                        stale
);

    localparam int SAMPLE_W = NUM_DIGITS + SEG_W;
    localparam int FRAME_W  = NUM_DIGITS * NIB_W;

    localparam logic [7:0]  STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0]  STABLE_PRE = 8'(STABLE_CYCLES - 1);
    localparam logic [23:0] IDLE_MAX   = 24'(TIMEOUT_CYCLES);

    // -------------------------------------------------------------------------
    // Sampling and stability tracking
    // -------------------------------------------------------------------------
    logic [SAMPLE_W-1:0] sample_d;
    logic [SAMPLE_W-1:0] sample_q;
    logic [7:0]          stable_cnt_q;
    logic                same_sample;

    assign sample_d    = {dig_en, seg_in};
    assign same_sample = (sample_d == sample_q);

    // stable_cnt_q is the run length of sample_q. A differing sample starts a
    // new run of length one; the count saturates so a long hold is accepted
    // only once.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q     <= '0;
            stable_cnt_q <= '0;
        end else begin
            sample_q <= sample_d;
            if (!same_sample) begin
                stable_cnt_q <= 8'd1;
            end else if (stable_cnt_q != STABLE_MAX) begin
                stable_cnt_q <= stable_cnt_q + 8'd1;
            end
        end
    end

    // The edge that takes the STABLE_CYCLES-th identical sample accepts it,
    // provided exactly one digit is enabled.
    logic accept;
    assign accept = same_sample && (stable_cnt_q == STABLE_PRE) && is_onehot(dig_en);

    // -------------------------------------------------------------------------
    // Decode
    // -------------------------------------------------------------------------
    logic [NIB_W-1:0] dec_nibble;
    logic             dec_error;

    seven_segment_pattern_decoder u_decoder (
        .seg_in (seg_in),
        .nibble (dec_nibble),
        .error  (dec_error)
    );

    // -------------------------------------------------------------------------
    // Shadow frame and publication
    // -------------------------------------------------------------------------
    logic [FRAME_W-1:0]    shadow_nib_q;
    logic [NUM_DIGITS-1:0] shadow_err_q;
    logic [NUM_DIGITS-1:0] seen_q;

    logic [FRAME_W-1:0]    shadow_nib_d;
    logic [NUM_DIGITS-1:0] shadow_err_d;
    logic [NUM_DIGITS-1:0] seen_d;
    logic                  frame_done;
    logic [1:0]            slot;

    assign slot = onehot_to_index(dig_en);

    // Shadow contents with the current digit merged in; used both to update
    // the shadow and to publish a frame on the same edge, so the completing
    // digit appears in the published frame.
    always_comb begin
        shadow_nib_d = shadow_nib_q;
        shadow_err_d = shadow_err_q;
        seen_d       = seen_q;
        if (accept) begin
            shadow_nib_d[slot*NIB_W +: NIB_W] = dec_nibble;
            shadow_err_d[slot]                = dec_error;
            seen_d                            = seen_q | dig_en;
        end
    end

    assign frame_done = accept && (seen_d == '1);

    // NOTE: the shadow is a small register bank, not a RAM, so it takes the
    // async reset like any other flop; that keeps a post-reset frame free of
    // leftovers from before reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_nib_q <= '0;
            shadow_err_q <= '0;
            seen_q       <= '0;
            digits       <= '0;
            err          <= '0;
            valid        <= 1'b0;
        end else begin
            valid <= frame_done;
            if (accept) begin
                shadow_nib_q <= shadow_nib_d;
                shadow_err_q <= shadow_err_d;
            end
            if (frame_done) begin
                digits <= shadow_nib_d;
                err    <= shadow_err_d;
                seen_q <= '0;
            end else begin
                seen_q <= seen_d;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Idle timeout
    // -------------------------------------------------------------------------
    logic [23:0] idle_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q <= '0;
        end else if (accept) begin
            idle_cnt_q <= '0;
        end else if (idle_cnt_q != IDLE_MAX) begin
            idle_cnt_q <= idle_cnt_q + 24'd1;
        end
    end

    assign stale = (idle_cnt_q == IDLE_MAX);

endmodule : seven_segment_scan_reader

// File: tb/tb_seven_segment_scan_reader.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_scan_reader
//   Directed bench for seven_segment_scan_reader with STABLE_CYCLES=4 and
//   TIMEOUT_CYCLES=16. Inputs change on the falling edge; outputs are
//   observed on the falling edge, half a cycle after the capturing edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seven_segment_scan_reader;

    localparam logic [6:0] P0 = 7'b1111110;
    localparam logic [6:0] P1 = 7'b0110000;
    localparam logic [6:0] P2 = 7'b1101101;
    localparam logic [6:0] P3 = 7'b1111001;
    localparam logic [6:0] P4 = 7'b0110011;
    localparam logic [6:0] P5 = 7'b1011011;
    localparam logic [6:0] P6 = 7'b1011111;
    localparam logic [6:0] P7 = 7'b1110000;
    localparam logic [6:0] P8 = 7'b1111111;
    localparam logic [6:0] P9 = 7'b1111011;
    localparam logic [6:0] PBAD = 7'b1000000;
    localparam logic [6:0] PBLANK = 7'b0000000;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  dig_en;
    logic [15:0] digits;
    logic        valid;
    logic [3:0]  err;
    logic        stale;

    int n_checks;
    int n_fail;
    int vpulses;
    int v0;

    seven_segment_scan_reader #(
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .seg_in (seg_in),
        .dig_en (dig_en),
        .digits (digits),
        .valid  (valid),
        .err    (err),
        .stale  (stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts published frames
    always @(negedge clk) begin
        if (valid === 1'b1) vpulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one digit at a falling edge and keep it for n rising edges
    task automatic hold(input logic [3:0] en, input logic [6:0] seg, input int n);
        dig_en = en;
        seg_in = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset(input bit check_outputs);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        if (check_outputs) begin
            check("rst_digits", 32'(digits), 32'h0);
            check("rst_err",    32'(err),    32'h0);
            check("rst_valid",  32'(valid),  32'h0);
            check("rst_stale",  32'(stale),  32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vpulses  = 0;
        rst_n    = 1'b0;
        seg_in   = '0;
        dig_en   = '0;
        @(negedge clk);
        #1;
        check("init_digits", 32'(digits), 32'h0);
        check("init_valid",  32'(valid),  32'h0);
        check("init_stale",  32'(stale),  32'h0);
        check("init_err",    32'(err),    32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic scan: 1,2,3,4 on digits 0..3, 8 cycles each
        v0 = vpulses;
        hold(4'b0001, P1, 8);
        hold(4'b0010, P2, 8);
        hold(4'b0100, P3, 8);
        hold(4'b1000, P4, 8);
        check("basic_pulses", 32'(vpulses - v0), 32'd1);
        check("basic_digits", 32'(digits), 32'h4321);
        check("basic_err",    32'(err),    32'h0);
        check("basic_stale",  32'(stale),  32'h0);

        // Error and blank digits, with exact valid timing on the last digit
        v0 = vpulses;
        hold(4'b0001, P7, 8);
        hold(4'b0010, PBAD, 8);
        hold(4'b0100, PBLANK, 8);
        hold(4'b1000, P9, 3);
        check("lat_valid_early", 32'(valid), 32'h0);
        check("lat_digits_hold", 32'(digits), 32'h4321);
        @(negedge clk);
        check("lat_valid_rise", 32'(valid),  32'h1);
        check("mixed_digits",   32'(digits), 32'h9FE7);
        check("mixed_err",      32'(err),    32'b0010);
        @(negedge clk);
        check("lat_valid_fall", 32'(valid),  32'h0);
        check("mixed_hold",     32'(digits), 32'h9FE7);
        hold(4'b1000, P9, 4);
        check("mixed_pulses",   32'(vpulses - v0), 32'd1);

        // Latest capture of a re-scanned digit wins
        v0 = vpulses;
        hold(4'b0001, P0, 8);
        hold(4'b0010, P5, 8);
        hold(4'b0010, P6, 8);
        hold(4'b0100, P8, 8);
        hold(4'b1000, P3, 8);
        check("rescan_pulses", 32'(vpulses - v0), 32'd1);
        check("rescan_nib1",   32'(digits[7:4]), 32'h6);
        check("rescan_digits", 32'(digits), 32'h3860);
        check("rescan_err",    32'(err),    32'h0);

        // A 3-cycle hold is too short; a later 4-cycle hold completes the frame
        v0 = vpulses;
        hold(4'b0001, P1, 3);
        hold(4'b0000, PBLANK, 2);
        hold(4'b0010, P2, 8);
        hold(4'b0100, P3, 8);
        hold(4'b1000, P4, 8);
        check("short_no_valid", 32'(vpulses - v0), 32'd0);
        check("short_digits",   32'(digits), 32'h3860);
        hold(4'b0001, P1, 3);
        check("short4_early", 32'(valid), 32'h0);
        @(negedge clk);
        check("short4_valid",  32'(valid),  32'h1);
        check("short4_digits", 32'(digits), 32'h4321);

        // Reset mid-frame discards digits 0,1
        hold(4'b0001, P5, 8);
        hold(4'b0010, P6, 8);
        pulse_reset(1'b1);
        v0 = vpulses;
        hold(4'b0100, P7, 8);
        hold(4'b1000, P8, 8);
        check("rstmid_no_valid", 32'(vpulses - v0), 32'd0);
        check("rstmid_digits0",  32'(digits), 32'h0);
        hold(4'b0001, P1, 8);
        hold(4'b0010, P2, 8);
        check("rstmid_pulses", 32'(vpulses - v0), 32'd1);
        check("rstmid_digits", 32'(digits), 32'h8721);

        // Multi-hot enable is never accepted; stale after 16 idle cycles
        pulse_reset(1'b0);
        v0 = vpulses;
        hold(4'b0011, P1, 15);
        check("stale_15", 32'(stale), 32'h0);
        hold(4'b0011, P1, 1);
        check("stale_16", 32'(stale), 32'h1);
        hold(4'b0011, P1, 4);
        check("stale_20",        32'(stale), 32'h1);
        check("multihot_no_val", 32'(vpulses - v0), 32'd0);
        check("multihot_digits", 32'(digits), 32'h0);
        hold(4'b0001, P1, 3);
        check("stale_pre_acc", 32'(stale), 32'h1);
        @(negedge clk);
        check("stale_cleared", 32'(stale), 32'h0);
        check("stale_no_valid", 32'(valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seven_segment_scan_reader
